pcra_address_unit: RTL and testbench

Owns the two 16-bit program-counter/return-address registers (PCRA0, PCRA1) that Pipeline Stage 0 drives through its increment strobes. Selects the active register with the PCRA flip flag, drives the instruction-fetch address bus, honours bus requests by releasing the bus, and accepts byte-wise loads from the data path for jumps, calls and returns. It is the responder side of the Stage 0 fetch/increment interface.

---
 rtl/pcra_pkg.sv | 14 +
 rtl/pcra_counter.sv | 42 ++++
 rtl/pcra_address_unit.sv | 73 +++++++
 tb/tb_pcra_address_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pcra_pkg.sv
// Shared constants for the PCRA address unit: default width, LoadSel encodings and reset value.
package pcra_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 16;
  localparam int unsigned BYTE_W         = 8;

  localparam logic [1:0] SEL_P0_LO = 2'b00;
  localparam logic [1:0] SEL_P0_HI = 2'b01;
  localparam logic [1:0] SEL_P1_LO = 2'b10;
  localparam logic [1:0] SEL_P1_HI = 2'b11;

  localparam logic [ADDR_W_DEFAULT-1:0] PCRA_RESET_VAL = '0;

endpackage

// File: rtl/pcra_counter.sv
// One PCRA register: byte-wise load from the data path, or increment by one.
// A load on the same edge as an increment wins and the increment is dropped.
module pcra_counter
  import pcra_pkg::*;
#(
  parameter int unsigned Width = ADDR_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic              load_en_i,
  input  logic              load_hi_i,
  input  logic [BYTE_W-1:0] load_byte_i,
  output logic [Width-1:0]  value_o
);

  logic [Width-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (load_en_i) begin
      if (load_hi_i) begin
        value_d[2*BYTE_W-1:BYTE_W] = load_byte_i;
      end else begin
        value_d[BYTE_W-1:0] = load_byte_i;
      end
    end else if (inc_i) begin
      value_d = value_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= Width'(PCRA_RESET_VAL);
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/pcra_address_unit.sv
// Program-counter/return-address pair: Flip-selected fetch address, bus release on
// BusRequest, byte loads from the data path and a sticky fault for strobes lost to the bus.
module pcra_address_unit
  import pcra_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              ClockIn,
  input  logic              Reset,
  input  logic              Pipe0Out_0_IncPCRA0,
  input  logic              Pipe0Out_1_IncPCRA1,
  input  logic              Flags_5_PCRA_Flip,
  input  logic              BusRequest,
  input  logic              LoadEn,
  input  logic [1:0]        LoadSel,
  input  logic [BYTE_W-1:0] LoadByte,
  output logic [ADDR_W-1:0] Addr,
  output logic              AddrOE,
  output logic [ADDR_W-1:0] PCRA0,
  output logic [ADDR_W-1:0] PCRA1,
  output logic              IncFault
);

  logic inc0, inc1, load0, load1, load_hi;
  logic fault_d, fault_q;

  // Strobes are lost while an external master owns the bus; loads are not.
  assign inc0    = Pipe0Out_0_IncPCRA0 && !BusRequest;
  assign inc1    = Pipe0Out_1_IncPCRA1 && !BusRequest;
  assign load0   = LoadEn && ((LoadSel == SEL_P0_LO) || (LoadSel == SEL_P0_HI));
  assign load1   = LoadEn && ((LoadSel == SEL_P1_LO) || (LoadSel == SEL_P1_HI));
  assign load_hi = (LoadSel == SEL_P0_HI) || (LoadSel == SEL_P1_HI);

  pcra_counter #(.Width(ADDR_W)) u_pcra0 (
    .clk_i       (ClockIn),
    .rst_i       (Reset),
    .inc_i       (inc0),
    .load_en_i   (load0),
    .load_hi_i   (load_hi),
    .load_byte_i (LoadByte),
    .value_o     (PCRA0)
  );

  pcra_counter #(.Width(ADDR_W)) u_pcra1 (
    .clk_i       (ClockIn),
    .rst_i       (Reset),
    .inc_i       (inc1),
    .load_en_i   (load1),
    .load_hi_i   (load_hi),
    .load_byte_i (LoadByte),
    .value_o     (PCRA1)
  );

  always_comb begin
    fault_d = fault_q;
    if (BusRequest && (Pipe0Out_0_IncPCRA0 || Pipe0Out_1_IncPCRA1)) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign IncFault = fault_q;
  assign Addr     = Flags_5_PCRA_Flip ? PCRA1 : PCRA0;
  assign AddrOE   = !Reset && !BusRequest;

endmodule

// File: tb/tb_pcra_address_unit.sv
// Bench for pcra_address_unit: directed vector table, hand sequences for combinational
// paths, and random traffic against a byte-level reference model of the two registers.
module tb_pcra_address_unit;

  logic        clk = 1'b0;
  logic        rst, inc0, inc1, flip, bus, le;
  logic [1:0]  sel;
  logic [7:0]  lbyte;
  logic [15:0] addr, p0, p1;
  logic        oe, fault;

  int checks = 0;
  int passes = 0;

  // Reference state
  logic [15:0] m0, m1;
  logic        mf;
  logic        mvalid = 1'b0;

  always #5 clk = ~clk;

  pcra_address_unit dut (
    .ClockIn             (clk),
    .Reset               (rst),
    .Pipe0Out_0_IncPCRA0 (inc0),
    .Pipe0Out_1_IncPCRA1 (inc1),
    .Flags_5_PCRA_Flip   (flip),
    .BusRequest          (bus),
    .LoadEn              (le),
    .LoadSel             (sel),
    .LoadByte            (lbyte),
    .Addr                (addr),
    .AddrOE              (oe),
    .PCRA0               (p0),
    .PCRA1               (p1),
    .IncFault            (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_in(input logic r, input logic i0, input logic i1, input logic f,
                        input logic b, input logic l, input logic [1:0] s,
                        input logic [7:0] d);
    rst = r; inc0 = i0; inc1 = i1; flip = f; bus = b; le = l; sel = s; lbyte = d;
  endtask

  function automatic logic [15:0] put_byte(input logic [15:0] v, input logic hi,
                                           input logic [7:0] d);
    logic [15:0] r;
    r = v;
    if (hi) r[15:8] = d;
    else    r[7:0]  = d;
    return r;
  endfunction

  // Advance the model by one rising edge using the current inputs.
  task automatic model_edge();
    if (rst) begin
      m0 = 16'h0000; m1 = 16'h0000; mf = 1'b0; mvalid = 1'b1;
    end else begin
      if (le && sel[1] == 1'b0)  m0 = put_byte(m0, sel[0], lbyte);
      else if (inc0 && !bus)     m0 = m0 + 16'd1;
      if (le && sel[1] == 1'b1)  m1 = put_byte(m1, sel[0], lbyte);
      else if (inc1 && !bus)     m1 = m1 + 16'd1;
      if (bus && (inc0 || inc1)) mf = 1'b1;
    end
  endtask

  // Inputs already applied mid-low-phase; check combinational outputs, clock, check state.
  task automatic step(input string tag);
    #1;
    check({tag, " AddrOE pre-edge"}, 32'(oe), 32'(!rst && !bus));
    if (mvalid) check({tag, " Addr pre-edge"}, 32'(addr), 32'(flip ? m1 : m0));
    @(posedge clk);
    model_edge();
    #1;
    check({tag, " PCRA0"}, 32'(p0), 32'(m0));
    check({tag, " PCRA1"}, 32'(p1), 32'(m1));
    check({tag, " IncFault"}, 32'(fault), 32'(mf));
    check({tag, " Addr"}, 32'(addr), 32'(flip ? m1 : m0));
    @(negedge clk);
  endtask

  typedef struct {
    logic        r, i0, i1, f, b, l;
    logic [1:0]  s;
    logic [7:0]  d;
    logic [15:0] e0, e1, ea;
    logic        ef;
  } vec_t;

  vec_t vt[$];

  initial begin
    vt.push_back('{1,0,0,0,0,0,2'b00,8'h00, 16'h0000,16'h0000,16'h0000,0});
    vt.push_back('{0,1,0,0,0,0,2'b00,8'h00, 16'h0001,16'h0000,16'h0001,0});
    vt.push_back('{0,1,0,0,0,0,2'b00,8'h00, 16'h0002,16'h0000,16'h0002,0});
    vt.push_back('{0,1,0,0,0,0,2'b00,8'h00, 16'h0003,16'h0000,16'h0003,0});
    vt.push_back('{0,0,0,0,0,1,2'b11,8'hFF, 16'h0003,16'hFF00,16'h0003,0});
    vt.push_back('{0,0,0,0,0,1,2'b10,8'hFF, 16'h0003,16'hFFFF,16'h0003,0});
    vt.push_back('{0,0,1,1,0,0,2'b00,8'h00, 16'h0003,16'h0000,16'h0000,0});
    vt.push_back('{0,0,0,0,0,1,2'b10,8'hFF, 16'h0003,16'h00FF,16'h0003,0});
    vt.push_back('{0,0,1,1,0,0,2'b00,8'h00, 16'h0003,16'h0100,16'h0100,0});
    vt.push_back('{0,0,0,0,0,1,2'b00,8'h34, 16'h0034,16'h0100,16'h0034,0});
    vt.push_back('{0,0,0,0,0,1,2'b01,8'h12, 16'h1234,16'h0100,16'h1234,0});
    vt.push_back('{0,0,0,0,0,1,2'b10,8'hCD, 16'h1234,16'h01CD,16'h1234,0});
    vt.push_back('{0,0,0,1,0,1,2'b11,8'hAB, 16'h1234,16'hABCD,16'hABCD,0});
    vt.push_back('{0,0,0,0,0,1,2'b01,8'h10, 16'h1034,16'hABCD,16'h1034,0});
    vt.push_back('{0,0,0,0,0,1,2'b00,8'hFF, 16'h10FF,16'hABCD,16'h10FF,0});
    // Load beats increment on PCRA0 (no carry); PCRA1 still increments.
    vt.push_back('{0,1,1,0,0,1,2'b00,8'h42, 16'h1042,16'hABCE,16'h1042,0});
    vt.push_back('{0,1,0,0,1,0,2'b00,8'h00, 16'h1042,16'hABCE,16'h1042,1});
    vt.push_back('{0,0,0,0,0,0,2'b00,8'h00, 16'h1042,16'hABCE,16'h1042,1});
    vt.push_back('{0,0,0,1,1,1,2'b00,8'h77, 16'h1077,16'hABCE,16'hABCE,1});
    vt.push_back('{0,0,0,0,0,0,2'b00,8'h00, 16'h1077,16'hABCE,16'h1077,1});
    vt.push_back('{1,1,1,0,0,1,2'b01,8'h55, 16'h0000,16'h0000,16'h0000,0});

    set_in(1, 0, 0, 0, 0, 0, 2'b00, 8'h00);
    @(negedge clk);

    foreach (vt[i]) begin
      set_in(vt[i].r, vt[i].i0, vt[i].i1, vt[i].f, vt[i].b, vt[i].l, vt[i].s, vt[i].d);
      #1;
      check($sformatf("vec%0d AddrOE", i), 32'(oe), 32'(!vt[i].r && !vt[i].b));
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("vec%0d PCRA0", i), 32'(p0), 32'(vt[i].e0));
      check($sformatf("vec%0d PCRA1", i), 32'(p1), 32'(vt[i].e1));
      check($sformatf("vec%0d Addr", i), 32'(addr), 32'(vt[i].ea));
      check($sformatf("vec%0d IncFault", i), 32'(fault), 32'(vt[i].ef));
      @(negedge clk);
    end

    // Flip switches Addr combinationally without touching either register.
    set_in(0, 0, 0, 0, 0, 1, 2'b00, 8'h34); step("ldA");
    set_in(0, 0, 0, 0, 0, 1, 2'b01, 8'h12); step("ldB");
    set_in(0, 0, 0, 0, 0, 1, 2'b10, 8'hCD); step("ldC");
    set_in(0, 0, 0, 0, 0, 1, 2'b11, 8'hAB); step("ldD");
    set_in(0, 0, 0, 0, 0, 0, 2'b00, 8'h00);
    #1 check("flip0 Addr", 32'(addr), 32'h1234);
    flip = 1'b1;
    #1 check("flip1 Addr", 32'(addr), 32'hABCD);
    flip = 1'b0;
    #1 check("flip0b Addr", 32'(addr), 32'h1234);
    step("flip hold");

    // BusRequest drives AddrOE combinationally on both edges of the request.
    bus = 1'b1;
    #1 check("bus rise AddrOE", 32'(oe), 32'h0);
    bus = 1'b0;
    #1 check("bus fall AddrOE", 32'(oe), 32'h1);

    // Increment wrap at 0xFFFF on PCRA0.
    set_in(0, 0, 0, 0, 0, 1, 2'b00, 8'hFF); step("wrapA");
    set_in(0, 0, 0, 0, 0, 1, 2'b01, 8'hFF); step("wrapB");
    set_in(0, 1, 0, 0, 0, 0, 2'b00, 8'h00); step("wrapC");
    check("wrap PCRA0", 32'(p0), 32'h0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(39) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(3) == 0), ($urandom_range(2) == 0), 2'($urandom), 8'($urandom));
      step($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
